// File: rtl/nr_div_sequencer.sv
// nr_div_sequencer: multi-cycle sign-magnitude Q(N-Q).Q divider, quotient = a / b.
// Newton-Raphson reciprocal refinement x <- x * (2 - |b| * x) on one shared
// saturating multiplier and one shared sign-magnitude adder, sequenced by an FSM.
module nr_div_sequencer #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int ITERS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic         div_by_zero,
  output logic         busy
);

  localparam int M  = N - 1;          // magnitude width
  localparam int PW = $clog2(M);      // width of a bit index into the magnitude
  localparam logic [3:0]   ITERS_C = 4'(ITERS);
  localparam logic [N-1:0] TWO     = {{(N-Q-2){1'b0}}, 2'b10, {Q{1'b0}}};
  localparam logic [M-1:0] MAG_ONE = {{(M-1){1'b0}}, 1'b1};
  localparam logic [M-1:0] MAG_MAX = {M{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_MUL_T, S_SUB, S_MUL_X, S_FINAL, S_DONE
  } state_t;

  // Saturating sign-magnitude fixed-point multiply; sign is the XOR of operand signs.
  function automatic logic [N-1:0] mul_sm(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*M-1:0] prod;
    logic [M-1:0]   mag;
    prod = {{M{1'b0}}, x[M-1:0]} * {{M{1'b0}}, y[M-1:0]};
    if (|prod[2*M-1:M+Q]) begin
      mag = MAG_MAX;
    end else begin
      mag = prod[M+Q-1:Q];
    end
    return {x[N-1] ^ y[N-1], mag};
  endfunction

  // Sign-magnitude add; exact cancellation yields +0, magnitude overflow saturates.
  function automatic logic [N-1:0] add_sm(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [M:0]   sum;
    logic [M-1:0] mag;
    logic         sgn;
    sum = {1'b0, x[M-1:0]} + {1'b0, y[M-1:0]};
    if (x[N-1] == y[N-1]) begin
      mag = sum[M] ? MAG_MAX : sum[M-1:0];
      sgn = x[N-1];
    end else if (x[M-1:0] > y[M-1:0]) begin
      mag = x[M-1:0] - y[M-1:0];
      sgn = x[N-1];
    end else if (y[M-1:0] > x[M-1:0]) begin
      mag = y[M-1:0] - x[M-1:0];
      sgn = y[N-1];
    end else begin
      mag = '0;
      sgn = 1'b0;
    end
    return {sgn, mag};
  endfunction

  // Index of the highest set bit (0 when none; the caller tests for zero separately).
  function automatic logic [PW-1:0] msb_idx(input logic [M-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < M; i++) begin
      if (v[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   x_q, x_d, u_q, u_d;
  logic [M-1:0]   t_q, t_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           dbz_q, dbz_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic           div_by_zero_q, div_by_zero_d;

  logic [N-1:0]   mul_a_s, mul_b_s, mul_y_s;
  logic [N-1:0]   add_a_s, add_b_s, add_y_s;
  logic [PW-1:0]  p_s, seed_sh_s;
  logic [M-1:0]   seed_s;
  logic           b_zero_s;
  logic [M-1:0]   fin_mag_s;

  assign mul_y_s   = mul_sm(mul_a_s, mul_b_s);
  assign add_y_s   = add_sm(add_a_s, add_b_s);
  assign b_zero_s  = (b_q[M-1:0] == '0);
  assign p_s       = msb_idx(b_q[M-1:0]);
  // Seed 2^(M-p) puts |b|*x in [0.5,1); p=0 would overflow the magnitude, so clip.
  assign seed_sh_s = (p_s == '0) ? PW'(M - 1) : (PW'(M) - p_s);
  assign seed_s    = MAG_ONE << seed_sh_s;
  assign fin_mag_s = mul_y_s[M-1:0];

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign quotient    = quotient_q;
  assign div_by_zero = div_by_zero_q;

  // Route the shared multiplier and adder operands according to the current step.
  always_comb begin
    mul_a_s = '0;
    mul_b_s = '0;
    add_a_s = '0;
    add_b_s = '0;
    case (state_q)
      S_MUL_T: begin
        mul_a_s = {1'b0, b_q[M-1:0]};
        mul_b_s = x_q;
      end
      S_SUB: begin
        add_a_s = TWO;
        add_b_s = {1'b1, t_q};
      end
      S_MUL_X: begin
        mul_a_s = x_q;
        mul_b_s = u_q;
      end
      S_FINAL: begin
        mul_a_s = {1'b0, a_q[M-1:0]};
        mul_b_s = x_q;
      end
      default: begin
        mul_a_s = '0;
        mul_b_s = '0;
      end
    endcase
  end

  // Next-state and datapath register updates for the refinement sequence.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    x_d           = x_q;
    t_d           = t_q;
    u_d           = u_q;
    cnt_d         = cnt_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_SEED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEED: begin
        cnt_d = 4'd0;
        if (b_zero_s) begin
          // Zero divisor skips refinement; FINAL loads the saturated result.
          dbz_d   = 1'b1;
          state_d = S_FINAL;
        end else begin
          dbz_d   = 1'b0;
          x_d     = {1'b0, seed_s};
          state_d = S_MUL_T;
        end
      end
      S_MUL_T: begin
        t_d     = mul_y_s[M-1:0];
        state_d = S_SUB;
      end
      S_SUB: begin
        u_d     = add_y_s;
        state_d = S_MUL_X;
      end
      S_MUL_X: begin
        x_d   = mul_y_s;
        cnt_d = cnt_q + 4'd1;
        if ((cnt_q + 4'd1) == ITERS_C) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_MUL_T;
        end
      end
      S_FINAL: begin
        if (dbz_q) begin
          quotient_d    = {a_q[N-1], MAG_MAX};
          div_by_zero_d = 1'b1;
        end else begin
          // A zero magnitude never carries a sign.
          quotient_d    = {(fin_mag_s != '0) & (a_q[N-1] ^ b_q[N-1]), fin_mag_s};
          div_by_zero_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      x_q           <= '0;
      t_q           <= '0;
      u_q           <= '0;
      cnt_q         <= 4'd0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      x_q           <= x_d;
      t_q           <= t_d;
      u_q           <= u_d;
      cnt_q         <= cnt_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

endmodule
